// File: rtl/ofifo_drain_ctrl.sv
// Output-FIFO drain sequencer: pops num_words complete vectors from the core's
// registered-read output FIFO and writes them to consecutive SRAM addresses.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | waiting for ofifo_valid & ~hold to pop the head vector
// POP    | ofifo_rd and mem_we high for this single cycle
// SETTLE | FIFO applies the registered read; ofifo_valid not trusted yet
// DONE   | one-cycle done pulse, then back to IDLE
module ofifo_drain_ctrl #(
    parameter int COL = 8,
    parameter int BW  = 4,
    parameter int AW  = 11,
    parameter int CW  = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CW-1:0]       num_words,
    input  logic [AW-1:0]       base_addr,
    input  logic                hold,
    input  logic                ofifo_valid,
    input  logic [COL*BW-1:0]   ofifo_out,
    output logic                ofifo_rd,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [COL*BW-1:0]   mem_din,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_POP    = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] rem_q;
    logic          accept;
    logic          pop_go;
    logic          rd_d;
    logic          we_d;
    logic          busy_d;
    logic          done_d;

    assign accept = (state_q == S_IDLE) && start;
    assign pop_go = (state_q == S_CHECK) && ofifo_valid && !hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_words != '0) ? S_CHECK : S_DONE;
                end
            end
            S_CHECK: begin
                if (pop_go) begin
                    state_d = S_POP;
                end
            end
            S_POP:    state_d = S_SETTLE;
            S_SETTLE: state_d = (rem_q != '0) ? S_CHECK : S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state they belong to.
    always_comb begin
        rd_d   = 1'b0;
        we_d   = 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_POP) begin
            rd_d = 1'b1;
            we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ofifo_rd <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
        end else begin
            ofifo_rd <= rd_d;
            mem_we   <= we_d;
            busy     <= busy_d;
            done     <= done_d;
            if (accept) begin
                addr_q <= base_addr;
                rem_q  <= num_words;
            end
            if (pop_go) begin
                mem_din  <= ofifo_out;
                mem_addr <= addr_q;
                addr_q   <= addr_q + AW'(1);
                rem_q    <= rem_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Bench for ofifo_drain_ctrl: registered-read FIFO model, write scoreboard and
// cycle-exact latency expectations derived from the 3-cycles-per-word rule.
module tb_ofifo_drain_ctrl;
    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int AW  = 11;
    localparam int CW  = 7;
    localparam int DW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic [AW-1:0] base_addr = '0;
    logic          hold = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [DW-1:0] ofifo_out = '0;
    logic          ofifo_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          done;

    ofifo_drain_ctrl #(.COL(COL), .BW(BW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .base_addr(base_addr), .hold(hold), .ofifo_valid(ofifo_valid),
        .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read request registered once, head advances on the following edge
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_vec[$];
    logic          rd_seen = 1'b0;
    logic          rd_int = 1'b0;
    int            underflow = 0;

    task automatic refresh();
        ofifo_valid = (fq.size() != 0);
        if (fq.size() != 0) ofifo_out = fq[0];
        else ofifo_out = '0;
    endtask

    task automatic push_vec(input logic [DW-1:0] v);
        fq.push_back(v);
        exp_vec.push_back(v);
        refresh();
    endtask

    always @(negedge clk) rd_seen = ofifo_rd;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            fq.delete();
            rd_int = 1'b0;
        end else begin
            if (rd_int) begin
                if (fq.size() > 0) void'(fq.pop_front());
                else underflow++;
            end
            rd_int = rd_seen;
        end
        refresh();
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t  wq[$];
    int   rdq[$];
    int   doneq[$];
    int   last_rd = -100;
    int   rd_viol = 0;
    logic pv = 1'b0;
    logic ph = 1'b0;

    always @(negedge clk) begin
        #2;
        if (mem_we) wq.push_back({mem_addr, mem_din});
        if (ofifo_rd) begin
            rdq.push_back(cyc);
            if ((cyc - last_rd) < 3 || !(pv && !ph)) rd_viol++;
            last_rd = cyc;
        end
        if (done) doneq.push_back(cyc);
        pv = ofifo_valid;
        ph = hold;
    end

    int n_total = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic start_drain(input int n, input logic [AW-1:0] base, output int s);
        wq.delete();
        rdq.delete();
        doneq.delete();
        @(negedge clk);
        num_words = CW'(n);
        base_addr = base;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_drain(input string tag, input int n, input logic [AW-1:0] base,
                                input int s, input bit timed);
        int k = 0;
        while (doneq.size() == 0 && k < 3 * n + 300) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        check($sformatf("%s done_count", tag), 64'(doneq.size()), 64'd1);
        if (timed && doneq.size() > 0)
            check($sformatf("%s done_cycle", tag), 64'(doneq[0] - s), 64'(1 + 3 * n));
        check($sformatf("%s write_count", tag), 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), 64'(wq[i].a), 64'((int'(base) + i) % (1 << AW)));
            check($sformatf("%s data[%0d]", tag, i), 64'(wq[i].d), 64'(exp_vec[i]));
        end
        if (timed) begin
            check($sformatf("%s rd_count", tag), 64'(rdq.size()), 64'(n));
            for (int i = 0; i < rdq.size(); i++)
                check($sformatf("%s rd_cycle[%0d]", tag, i), 64'(rdq[i] - s), 64'(2 + 3 * i));
        end
        check($sformatf("%s fifo_empty", tag), 64'(fq.size()), 64'd0);
        exp_vec.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check($sformatf("%s ofifo_rd", tag), 64'(ofifo_rd), 64'd0);
        check($sformatf("%s mem_we", tag), 64'(mem_we), 64'd0);
        check($sformatf("%s mem_addr", tag), 64'(mem_addr), 64'd0);
        check($sformatf("%s mem_din", tag), 64'(mem_din), 64'd0);
        check($sformatf("%s busy", tag), 64'(busy), 64'd0);
        check($sformatf("%s done", tag), 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        logic [AW-1:0] b;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic drain
        push_vec(32'h11111111);
        push_vec(32'h22222222);
        push_vec(32'h33333333);
        push_vec(32'h44444444);
        start_drain(4, 11'h010, s);
        finish_drain("basic", 4, 11'h010, s, 1'b1);

        // Zero count
        start_drain(0, AW'($urandom), s);
        finish_drain("zero", 0, 11'h000, s, 1'b1);

        // Starvation and hold
        push_vec($urandom);
        b = AW'($urandom);
        start_drain(2, b, s);
        while (cyc < s + 10) @(negedge clk);
        hold = 1'b1;
        push_vec($urandom);
        repeat (5) @(negedge clk);
        hold = 1'b0;
        finish_drain("starve", 2, b, s, 1'b0);
        check("starve rd_count", 64'(rdq.size()), 64'd2);
        if (rdq.size() == 2) begin
            check("starve rd0_cycle", 64'(rdq[0] - s), 64'd2);
            check("starve rd1_cycle", 64'(rdq[1] - s), 64'd16);
        end

        // Full depth with address wrap
        for (int i = 0; i < 64; i++) push_vec($urandom);
        start_drain(64, 11'h7F0, s);
        finish_drain("full", 64, 11'h7F0, s, 1'b1);

        // Reset during the third POP of an 8-word drain
        for (int i = 0; i < 8; i++) push_vec($urandom);
        start_drain(8, AW'($urandom), s);
        while (cyc < s + 8) @(negedge clk);
        check("mid_reset pop_active", 64'(ofifo_rd), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset stays_idle_busy", 64'(busy), 64'd0);
        check("mid_reset stays_idle_we", 64'(mem_we), 64'd0);
        exp_vec.delete();
        for (int i = 0; i < 8; i++) push_vec($urandom);
        b = AW'($urandom);
        start_drain(8, b, s);
        finish_drain("after_reset", 8, b, s, 1'b1);

        // Start while busy is ignored
        for (int i = 0; i < 4; i++) push_vec($urandom);
        b = AW'($urandom);
        start_drain(4, b, s);
        while (cyc < s + 3) @(negedge clk);
        num_words = 7'd9;
        base_addr = b + 11'h155;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_drain("ignored_start", 4, b, s, 1'b1);

        // Randomised drains
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 20));
            b = AW'($urandom);
            for (int i = 0; i < n; i++) push_vec($urandom);
            start_drain(n, b, s);
            finish_drain($sformatf("rand%0d", r), n, b, s, 1'b1);
        end

        check("rd_spacing_and_gating", 64'(rd_viol), 64'd0);
        check("fifo_underflow", 64'(underflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ofifo_drain_ctrl.md
# ofifo_drain_ctrl

Sequencer that empties the output FIFO (column-parallel, registered-read) of the systolic core into the output SRAM. On `start` it pops exactly `num_words` complete output vectors, each popped only when every column holds data. Each popped vector is written to consecutive SRAM addresses from `base_addr`, then a one-cycle `done` pulses. It sits between the core's output FIFO and the output-SRAM write port and is the only driver of the FIFO's `rd` input.

## Interface
- `COL`, 8, number of FIFO columns
- `BW`, 4, bits per column; vector width = `COL*BW`
- `AW`, 11, SRAM address width
- `CW`, 7, word-count width (max drain 64 = FIFO depth)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  begin drain; sampled only in IDLE
- `num_words`  in  CW  vectors to drain; latched on accepted `start`
- `base_addr`  in  AW  first SRAM address; latched on accepted `start`
- `hold`  in  1  SRAM port busy; suppresses new pops while high
- `ofifo_valid`  in  1  all columns non-empty (FIFO `o_valid`)
- `ofifo_out`  in  COL*BW  FIFO head vector
- `ofifo_rd`  out  1  FIFO read request; FIFO registers it internally (+1 cycle)
- `mem_we`  out  1  SRAM write enable, active-high
- `mem_addr`  out  AW  SRAM write address
- `mem_din`  out  COL*BW  SRAM write data
- `busy`  out  1  high from accepted `start` until the cycle `done` is high (inclusive)
- `done`  out  1  one-cycle pulse after the last write

## Operation
- FSM states and transitions:
  - IDLE -> CHECK on `start`, when latched `num_words` != 0.
  - IDLE -> DONE on `start` with `num_words` == 0. No pop and no write occur.
  - CHECK -> POP when `ofifo_valid & ~hold`. Otherwise stay in CHECK.
  - POP -> SETTLE, unconditionally.
  - SETTLE -> CHECK when remaining != 0. SETTLE -> DONE when remaining == 0.
  - DONE -> IDLE, unconditionally.
- Registers:
  - `addr_q` is loaded with `base_addr` and increments by 1 per pop. It wraps modulo 2^AW with no flag.
  - `rem_q` is loaded with `num_words` and decrements by 1 per pop.
- CHECK->POP transition edge: capture `ofifo_out` into `mem_din`, `addr_q` into `mem_addr`, and decrement `rem_q`.
- In POP: `ofifo_rd=1` and `mem_we=1` for exactly one cycle.
- All outputs are registered. `mem_din` and `mem_addr` hold their last values outside POP.
- SETTLE exists because the FIFO's read is registered. The head pointer and `ofifo_valid` reflect a pop only 2 cycles after `ofifo_rd` rises. The FSM never evaluates `ofifo_valid` in that window. This prevents double-pops and reads of a stale head.
- `start` in any state other than IDLE is ignored. Latched parameters are not disturbed.
- `hold` only gates the CHECK->POP decision. A POP already underway completes.
- `ofifo_valid` low in CHECK stalls indefinitely. There is no timeout.
- Reset, including mid-drain:
  - The FSM goes to IDLE and all outputs go to 0: `ofifo_rd`, `mem_we`, `mem_addr`, `mem_din`, `busy`, `done`.
  - `addr_q` and `rem_q` go to 0.
  - A pop in flight inside the FIFO is not recalled. The FIFO is reset by the same signal.

## Timing
- Cycle t, state CHECK with `ofifo_valid=1` and `hold=0`: decision made.
- Cycle t+1: state POP. `ofifo_rd=1`, `mem_we=1`, `mem_din` = head vector of cycle t.
- Cycle t+2: state SETTLE. The FIFO's internal read enable is high.
- Cycle t+3: CHECK again with the updated head/valid, or DONE if `rem_q` = 0.
- Peak throughput: 1 vector per 3 cycles.
- `start` at cycle s: CHECK at s+1, first possible POP at s+2.
- Total latency for N words with FIFO always valid: `done` high at cycle s+1+3N. That is 3 cycles per word (CHECK, POP, SETTLE), then DONE, with IDLE at s+2+3N.
- `busy` rises at s+1 and falls after the DONE cycle.
- `ofifo_rd` is never high on two cycles closer than 3 apart.

## Test plan
- Basic drain: FIFO preloaded with 4 vectors 0x11111111..0x44444444, `start`, `num_words=4`, `base_addr=0x010`.
  - Required: writes to 0x010..0x013 with those values in order.
  - `ofifo_rd` pulses at s+2, s+5, s+8, s+11.
  - `done` at s+13, and the FIFO is empty afterwards.
- Zero count: `start` with `num_words=0`.
  - Required: `done` at s+1, with no `mem_we` and no `ofifo_rd`.
- Starvation and `hold`: 2 vectors requested, but only 1 present.
  - Second vector arrives 10 cycles later. Also raise `hold` for 5 cycles while `ofifo_valid=1`.
  - Required: no pop while `ofifo_valid=0` or `hold=1`. Exactly 2 writes, correct data.
- Full depth and wrap: `num_words=64`, `base_addr=0x7F0` with AW=11.
  - Required: 64 writes, addresses 0x7F0..0x7FF then 0x000..0x02F.
  - `done` at s+193, FIFO empty.
- Reset mid-drain: assert `reset` 1 cycle during the 3rd POP of an 8-word drain.
  - Required: all outputs 0 the following cycle and FSM in IDLE.
  - A new `start` then performs a full drain.
- Ignored start: pulse `start` with different parameters while busy.
  - Required: the original `num_words`/`base_addr` complete unchanged, with a single `done`.
